bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares a single external memory bus (Wishbone-classic style) between two requesters: the instruction-fetch port (IF stage) and the data port (MEM stage load/store).
- Sequences each access as one bus cycle with a req/ack handshake.
- Raises per-stage stall requests to the pipeline controller while an access is outstanding.
- Enforces a bus timeout that returns an error instead of hanging the pipeline.

Parameters:
TIMEOUT, 16, maximum cycles m_stb_o may stay high without m_ack_i before the access is terminated with error (≥2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
flush_i  input  1  pipeline flush; discards in-flight/pending instruction fetch
i_req_i  input  1  IF fetch request, held high until i_ack_o or i_err_o
i_addr_i  input  32  IF fetch address
i_rdata_o  output  32  fetched instruction word
i_ack_o  output  1  one-cycle fetch completion pulse
i_err_o  output  1  one-cycle fetch timeout pulse
d_req_i  input  1  MEM access request, held until d_ack_o or d_err_o
d_we_i  input  1  1 = store, 0 = load
d_sel_i  input  4  byte enables
d_addr_i  input  32  data address
d_wdata_i  input  32  store data
d_rdata_o  output  32  load data
d_ack_o  output  1  one-cycle data completion pulse
d_err_o  output  1  one-cycle data timeout pulse
m_cyc_o  output  1  bus cycle active
m_stb_o  output  1  bus strobe
m_we_o  output  1  bus write enable
m_sel_o  output  4  bus byte enables
m_addr_o  output  32  bus address
m_wdata_o  output  32  bus write data
m_rdata_i  input  32  bus read data
m_ack_i  input  1  bus acknowledge
stallreq_if_o  output  1  IF stall request
stallreq_mem_o  output  1  MEM stall request

Behaviour:
- Reset: clk and rst are the port names; rst is asynchronous, active-low.
  - Assertion forces state IDLE, counter 0, all registered outputs 0.
  - This includes m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o, i_/d_rdata_o, and all ack/err pulses.
  - Reset mid-transaction abandons the bus cycle immediately; no ack or err is issued.
- FSM states: IDLE, DACC, IFETCH.
- IDLE:
  - d_req_i=1 → DACC. Data always has priority, since MEM holds the older instruction.
  - Else i_req_i=1 and flush_i=0 → IFETCH.
  - Else stay in IDLE.
  - On the transition edge: m_cyc_o=m_stb_o=1, and address, we, sel and wdata are registered from the granted port.
  - IFETCH drives m_we_o=0, m_sel_o=4'b1111, m_wdata_o=0.
- DACC / IFETCH:
  - Bus outputs held stable. Counter increments each cycle m_stb_o=1.
  - m_ack_i=1 sampled:
    - Next edge drops m_cyc_o/m_stb_o and captures m_rdata_i into the port's rdata_o (stores also capture it; value is don't-care to the requester).
    - Pulses that port's ack_o for one cycle, returns to IDLE, clears counter.
  - Counter reaches TIMEOUT-1 with no ack:
    - Next edge drops cyc/stb, pulses err_o, sets rdata_o=0, returns to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Latency: request sampled at edge N → stb high after N; zero-wait slave acks in that cycle → ack_o high after edge N+1 (2 cycles).
  - Back-to-back requests insert one IDLE cycle between bus cycles.
- flush_i:
  - In IDLE: blocks an IFETCH grant that cycle.
  - During IFETCH: sets a sticky discard flag. The bus cycle still completes normally, but i_ack_o/i_err_o are suppressed and i_rdata_o is not updated. The flag clears on return to IDLE.
  - Data accesses are unaffected.
- rdata_o holds its last value between transactions.
- Stall requests are combinational:
  - stallreq_mem_o = d_req_i & ~d_ack_o & ~d_err_o
  - stallreq_if_o = i_req_i & ~i_ack_o & ~i_err_o
- A request dropped before completion is a protocol violation. The arbiter still completes the bus cycle and issues the pulse; the requester ignores it.

Test Plan:
- Single load: d_req_i=1, d_addr_i=0x0000_0100, d_we_i=0, slave acks in the first stb cycle with 0xDEAD_BEEF → m_addr_o=0x100 one cycle after req; d_ack_o pulses at cycle 2 with d_rdata_o=0xDEAD_BEEF; stallreq_mem_o=1 in cycles 0–1, 0 in cycle 2.
- Contention: i_req_i and d_req_i rise together (i_addr 0x0, d store 0x200, sel=4'b0011, wdata=0x1234_5678) → data bus cycle first (m_we_o=1, m_sel_o=0011), one IDLE cycle, then fetch (m_sel_o=1111, m_we_o=0); stallreq_if_o stays high until i_ack_o.
- Wait states: slave delays ack 3 cycles on a fetch → m_stb_o high exactly 4 cycles, address stable throughout, i_ack_o one-cycle pulse after the ack edge.
- Timeout: TIMEOUT=16, slave never acks a load → m_stb_o high 16 cycles then drops; d_err_o pulses once, d_rdata_o=0, FSM returns to IDLE and accepts the next request.
- Flush: flush_i pulses during IFETCH while the slave waits 2 cycles → bus cycle completes, no i_ack_o, i_rdata_o keeps its previous value; the next fetch works normally.
- Async reset: rst driven low mid-DACC between clock edges → m_cyc_o/m_stb_o go 0 immediately, no ack/err afterwards, IDLE after release.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port arbiter sharing one Wishbone-classic memory bus between instruction fetch and data access.
// Data requests win over fetches, and a hung slave is cut off after TIMEOUT strobe cycles with an error.
module bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,

    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_rdata_o,
    output logic        i_ack_o,
    output logic        i_err_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        d_err_o,

    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ack_i,

    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IFETCH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             discard;
    logic             d_pend;
    logic             i_pend;
    logic             timeout_hit;
    logic             i_drop;

    // A request whose completion pulse is showing this cycle is already served.
    assign d_pend = d_req_i & ~d_ack_o & ~d_err_o;
    assign i_pend = i_req_i & ~i_ack_o & ~i_err_o;

    assign stallreq_mem_o = d_pend;
    assign stallreq_if_o  = i_pend;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign i_drop      = discard | flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            discard   <= 1'b0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_sel_o   <= 4'b0000;
            m_addr_o  <= '0;
            m_wdata_o <= '0;
            i_rdata_o <= '0;
            d_rdata_o <= '0;
            i_ack_o   <= 1'b0;
            i_err_o   <= 1'b0;
            d_ack_o   <= 1'b0;
            d_err_o   <= 1'b0;
        end else begin
            i_ack_o <= 1'b0;
            i_err_o <= 1'b0;
            d_ack_o <= 1'b0;
            d_err_o <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    discard <= 1'b0;
                    if (d_pend) begin
                        state     <= DACC;
                        m_cyc_o   <= 1'b1;
                        m_stb_o   <= 1'b1;
                        m_we_o    <= d_we_i;
                        m_sel_o   <= d_sel_i;
                        m_addr_o  <= d_addr_i;
                        m_wdata_o <= d_wdata_i;
                    end else if (i_pend && !flush_i) begin
                        state     <= IFETCH;
                        m_cyc_o   <= 1'b1;
                        m_stb_o   <= 1'b1;
                        m_we_o    <= 1'b0;
                        m_sel_o   <= 4'b1111;
                        m_addr_o  <= i_addr_i;
                        m_wdata_o <= '0;
                    end
                end

                // An ack arriving on the last allowed cycle still counts as success.
                DACC: begin
                    if (m_ack_i) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        d_rdata_o <= m_rdata_i;
                        d_ack_o   <= 1'b1;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        d_rdata_o <= '0;
                        d_err_o   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // A flushed fetch still finishes on the bus, but its result never reaches IF.
                IFETCH: begin
                    if (m_ack_i) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        discard <= 1'b0;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        if (!i_drop) begin
                            i_rdata_o <= m_rdata_i;
                            i_ack_o   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        discard <= 1'b0;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        if (!i_drop) begin
                            i_rdata_o <= '0;
                            i_err_o   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (flush_i) begin
                            discard <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    discard <= 1'b0;
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a slave model answers bus cycles with planned wait states,
// and a monitor matches every bus cycle and completion pulse against expectations queued by the stimulus.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
        int          start;
    } bus_exp_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
    } plan_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_ack_o;
    logic        i_err_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        m_ack_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    bus_exp_t bus_q[$];
    plan_t    plan_q[$];
    resp_t    d_q[$];
    resp_t    i_q[$];

    logic [31:0] model_d_rdata = '0;
    logic [31:0] model_i_rdata = '0;

    bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
        .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc_cnt);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // Slave: acks the planned number of wait states into each bus cycle, otherwise drives junk read data.
    int    wcnt = 0;
    bit    in_cycle = 1'b0;
    plan_t cur_plan;

    always @(negedge clk) begin
        m_rdata_i = $urandom;
        m_ack_i   = 1'b0;
        if (rst && m_stb_o) begin
            if (!in_cycle) begin
                in_cycle = 1'b1;
                wcnt     = 0;
                if (plan_q.size() != 0) begin
                    cur_plan = plan_q.pop_front();
                end else begin
                    cur_plan.delay = 0;
                    cur_plan.data  = '0;
                end
            end
            if (wcnt == cur_plan.delay) begin
                m_ack_i   = 1'b1;
                m_rdata_i = cur_plan.data;
            end
            wcnt++;
        end else begin
            in_cycle = 1'b0;
        end
    end

    // Monitor: pops an expectation whenever the DUT starts a bus cycle or shows a completion pulse.
    bit       stb_prev = 1'b0;
    bit       have_cur = 1'b0;
    bit       stable = 1'b1;
    int       stb_len = 0;
    bus_exp_t cur_bus;
    resp_t    e;

    always @(negedge clk) begin
        if (!rst) begin
            stb_prev = 1'b0;
            have_cur = 1'b0;
        end else begin
            checkFlag("cyc_eq_stb", m_cyc_o, m_stb_o);
            if (m_stb_o && !stb_prev) begin
                checkFlag("bus_cycle_expected", bus_q.size() != 0, 1'b1);
                if (bus_q.size() != 0) begin
                    cur_bus = bus_q.pop_front();
                    have_cur = 1'b1;
                    stable = 1'b1;
                    stb_len = 1;
                    checkFlag("bus_we", m_we_o, cur_bus.we);
                    checkOutput("bus_sel", {28'b0, m_sel_o}, {28'b0, cur_bus.sel});
                    checkOutput("bus_addr", m_addr_o, cur_bus.addr);
                    checkOutput("bus_wdata", m_wdata_o, cur_bus.wdata);
                    checkOutput("bus_start_cycle", cyc_cnt, cur_bus.start);
                end
            end else if (m_stb_o) begin
                stb_len++;
                if (have_cur && (m_addr_o !== cur_bus.addr || m_we_o !== cur_bus.we ||
                                 m_sel_o !== cur_bus.sel || m_wdata_o !== cur_bus.wdata))
                    stable = 1'b0;
            end else if (stb_prev && have_cur) begin
                checkOutput("stb_length", stb_len, cur_bus.len);
                checkFlag("bus_stable", stable, 1'b1);
                have_cur = 1'b0;
            end

            if (d_ack_o || d_err_o) begin
                checkFlag("d_resp_expected", d_q.size() != 0, 1'b1);
                if (d_q.size() != 0) begin
                    e = d_q.pop_front();
                    checkFlag("d_err", d_err_o, e.err);
                    checkFlag("d_ack", d_ack_o, !e.err);
                    checkOutput("d_rdata", d_rdata_o, e.rdata);
                    checkOutput("d_resp_cycle", cyc_cnt, e.cyc);
                end
            end
            if (i_ack_o || i_err_o) begin
                checkFlag("i_resp_expected", i_q.size() != 0, 1'b1);
                if (i_q.size() != 0) begin
                    e = i_q.pop_front();
                    checkFlag("i_err", i_err_o, e.err);
                    checkFlag("i_ack", i_ack_o, !e.err);
                    checkOutput("i_rdata", i_rdata_o, e.rdata);
                    checkOutput("i_resp_cycle", cyc_cnt, e.cyc);
                end
            end
            stb_prev = m_stb_o;
        end
    end

    // One scenario: optional data and/or fetch request raised together in cycle 0; called at a negedge.
    task automatic applyStimulus(input bit do_d, input bit dwe, input logic [3:0] dsel,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input int ddelay, input logic [31:0] ddata,
                                 input bit do_i, input logic [31:0] iaddr,
                                 input int idelay, input logic [31:0] idata, input bit flush_first);
        int       t0, dlen, ilen, dcomp, icomp, last;
        bit       dok, iok, d_act, i_act;
        bus_exp_t b;
        plan_t    p;
        resp_t    r;
        t0    = cyc_cnt;
        dok   = ddelay < TIMEOUT;
        iok   = idelay < TIMEOUT;
        dlen  = dok ? ddelay + 1 : TIMEOUT;
        ilen  = iok ? idelay + 1 : TIMEOUT;
        dcomp = do_d ? 1 + dlen : 0;
        icomp = do_i ? ((do_d ? dcomp + 1 : 1 + int'(flush_first)) + ilen) : 0;
        last  = (dcomp > icomp) ? dcomp : icomp;

        if (do_d) begin
            b.we = dwe; b.sel = dsel; b.addr = daddr; b.wdata = dwdata;
            b.len = dlen; b.start = t0 + 1;
            bus_q.push_back(b);
            p.delay = ddelay; p.data = ddata;
            plan_q.push_back(p);
            model_d_rdata = dok ? ddata : 32'h0;
            r.err = !dok; r.rdata = model_d_rdata; r.cyc = t0 + dcomp;
            d_q.push_back(r);
        end
        if (do_i) begin
            b.we = 1'b0; b.sel = 4'hF; b.addr = iaddr; b.wdata = '0;
            b.len = ilen; b.start = icomp - ilen + t0;
            bus_q.push_back(b);
            p.delay = idelay; p.data = idata;
            plan_q.push_back(p);
            model_i_rdata = iok ? idata : 32'h0;
            r.err = !iok; r.rdata = model_i_rdata; r.cyc = t0 + icomp;
            i_q.push_back(r);
        end

        d_req_i = do_d; d_we_i = dwe; d_sel_i = dsel; d_addr_i = daddr; d_wdata_i = dwdata;
        i_req_i = do_i; i_addr_i = iaddr; flush_i = flush_first;
        d_act = do_d; i_act = do_i;
        for (int k = 0; k <= last + 1; k++) begin
            if (k == 0) #1;
            else @(negedge clk);
            if (k == 1) flush_i = 1'b0;
            checkFlag("stallreq_mem", stallreq_mem_o, do_d && k < dcomp);
            checkFlag("stallreq_if", stallreq_if_o, do_i && k < icomp);
            if (d_act && (d_ack_o || d_err_o)) begin
                d_act = 1'b0;
                d_req_i = 1'b0;
            end
            if (i_act && (i_ack_o || i_err_o)) begin
                i_act = 1'b0;
                i_req_i = 1'b0;
            end
        end
        checkFlag("completion_within_budget", d_act | i_act, 1'b0);
        d_req_i = 1'b0; i_req_i = 1'b0; flush_i = 1'b0;
    endtask

    // Fetch that the pipeline flushes at cycle flush_k (1..delay+1) while it is on the bus.
    task automatic doFlushFetch(input logic [31:0] iaddr, input int idelay,
                                input logic [31:0] idata, input int flush_k);
        bus_exp_t b;
        plan_t    p;
        b.we = 1'b0; b.sel = 4'hF; b.addr = iaddr; b.wdata = '0;
        b.len = idelay + 1; b.start = cyc_cnt + 1;
        bus_q.push_back(b);
        p.delay = idelay; p.data = idata;
        plan_q.push_back(p);
        i_req_i = 1'b1; i_addr_i = iaddr; flush_i = 1'b0;
        for (int k = 1; k <= idelay + 4; k++) begin
            @(negedge clk);
            if (k == flush_k) begin
                flush_i = 1'b1;
                i_req_i = 1'b0;
            end else begin
                flush_i = 1'b0;
            end
        end
        checkOutput("flush_rdata_hold", i_rdata_o, model_i_rdata);
        checkFlag("flush_bus_done", m_cyc_o, 1'b0);
    endtask

    // Reset asserted between clock edges in the middle of a data access.
    task automatic doResetTest();
        bus_exp_t b;
        plan_t    p;
        b.we = 1'b1; b.sel = 4'hA; b.addr = 32'h0000_0300; b.wdata = 32'hCAFE_F00D;
        b.len = 0; b.start = cyc_cnt + 1;
        bus_q.push_back(b);
        p.delay = 99; p.data = 32'h1111_2222;
        plan_q.push_back(p);
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hA; d_addr_i = 32'h0000_0300; d_wdata_i = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        checkFlag("pre_reset_stb", m_stb_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkFlag("async_reset_cyc", m_cyc_o, 1'b0);
        checkFlag("async_reset_stb", m_stb_o, 1'b0);
        checkFlag("async_reset_we", m_we_o, 1'b0);
        checkOutput("async_reset_addr", m_addr_o, 32'h0);
        checkOutput("async_reset_wdata", m_wdata_o, 32'h0);
        checkOutput("async_reset_d_rdata", d_rdata_o, 32'h0);
        checkOutput("async_reset_i_rdata", i_rdata_o, 32'h0);
        d_req_i = 1'b0;
        model_d_rdata = '0;
        model_i_rdata = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkFlag("post_reset_idle", m_stb_o, 1'b0);
        checkFlag("post_reset_no_derr", d_err_o, 1'b0);
    endtask

    function automatic int randDelay();
        int r;
        r = $urandom_range(0, 11);
        if (r == 11) return $urandom_range(TIMEOUT, TIMEOUT + 3);
        if (r == 10) return TIMEOUT - 1;
        return $urandom_range(0, 4);
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        i_req_i = 1'b0; i_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
        repeat (3) @(negedge clk);
        checkFlag("reset_cyc", m_cyc_o, 1'b0);
        checkFlag("reset_stb", m_stb_o, 1'b0);
        checkFlag("reset_we", m_we_o, 1'b0);
        checkOutput("reset_sel", {28'b0, m_sel_o}, 32'h0);
        checkOutput("reset_addr", m_addr_o, 32'h0);
        checkOutput("reset_wdata", m_wdata_o, 32'h0);
        checkOutput("reset_d_rdata", d_rdata_o, 32'h0);
        checkOutput("reset_i_rdata", i_rdata_o, 32'h0);
        checkFlag("reset_d_ack", d_ack_o, 1'b0);
        checkFlag("reset_i_ack", i_ack_o, 1'b0);
        checkFlag("reset_d_err", d_err_o, 1'b0);
        checkFlag("reset_i_err", i_err_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed scenarios");
        applyStimulus(1, 0, 4'hF, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 1, 32'h5555_AAAA,
                      1, 32'h0000_0000, 0, 32'h0000_0013, 0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0000_0040, 3, 32'h00A0_0093, 0);
        applyStimulus(1, 0, 4'hF, 32'h0000_0400, 32'h0, 40, 32'h7777_7777, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 4'hF, 32'h0000_0404, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0000_0080, TIMEOUT, 32'h1, 0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0000_0084, 0, 32'hFEED_0001, 1);
        doFlushFetch(32'h0000_0088, 2, 32'h4444_4444, 2);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0000_008C, 0, 32'h6666_0006, 0);
        doFlushFetch(32'h0000_0090, 0, 32'h8888_8888, 1);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0000_0094, 1, 32'h9999_0009, 0);
        doResetTest();
        applyStimulus(1, 1, 4'b1100, 32'h0000_0500, 32'hABCD_0123, 0, 32'h2468_ACE0, 0, 32'h0, 0, 32'h0, 0);

        $display("[TB] randomized scenarios");
        for (int n = 0; n < 40; n++) begin
            bit dd, di;
            dd = 1'($urandom_range(0, 1));
            di = dd ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(dd, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                          randDelay(), $urandom, di, $urandom, randDelay(), $urandom,
                          1'($urandom_range(0, 3) == 0));
        end
        repeat (3) @(negedge clk);

        checkOutput("bus_q_drained", bus_q.size(), 32'h0);
        checkOutput("plan_q_drained", plan_q.size(), 32'h0);
        checkOutput("d_q_drained", d_q.size(), 32'h0);
        checkOutput("i_q_drained", i_q.size(), 32'h0);
        checkOutput("final_d_rdata", d_rdata_o, model_d_rdata);
        checkOutput("final_i_rdata", i_rdata_o, model_i_rdata);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
